// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: a single 1-bit full adder is time-shared
// LSB first over WIDTH cycles. The registered result is published on the
// completion edge, and done pulses for one cycle after it.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
  logic [CntW-1:0]  r_cnt;

  logic             w_x;
  logic             w_y;
  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_nxt;

  // The one shared full adder, fed from the operand LSBs and the carry flop
  assign w_x = r_a[0];
  assign w_y = r_b[0];
  assign w_s = w_x ^ w_y ^ r_carry;
  assign w_c = (w_x & w_y) | (w_x & r_carry) | (w_y & r_carry);

  // Sum bits enter from the MSB side so that after WIDTH shifts bit 0 holds the first sum bit
  assign w_acc_nxt = {w_s, r_acc[WIDTH-1:1]};
  assign w_last    = (r_cnt == CntW'(WIDTH - 1));

  // Control FSM, serial datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= StRun;
          end
        end
        StRun: begin
          r_acc   <= w_acc_nxt;
          r_carry <= w_c;
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_sum   <= w_acc_nxt;
            r_cout  <= w_c;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StDone;
          end
        end
        StDone: begin
          // start is deliberately ignored here
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: directed WIDTH=8 scenarios plus an
// exhaustive operand sweep on a WIDTH=4 instance.
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       cin4;
  logic       busy4;
  logic       done4;
  logic [3:0] sum4;
  logic       cout4;

  int checks   = 0;
  int failures = 0;
  int dones8   = 0;
  int dones4   = 0;

  logic [8:0] q8[$];
  logic [4:0] q4[$];
  logic [8:0] held8 = '0;
  logic [4:0] held4 = '0;

  serial_add_ctrl #(.WIDTH(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_add_ctrl #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the WIDTH=8 instance: result checks and hold-during-run checks
  always @(negedge clk) begin
    if (!rst_n) begin
      held8 = '0;
    end else begin
      if (busy) chk("hold8", {23'd0, cout, sum}, {23'd0, held8});
      if (done) begin
        dones8++;
        if (q8.size() == 0) begin
          chk("unexpected_done8", {31'd0, done}, 32'd0);
        end else begin
          chk("result8", {23'd0, cout, sum}, {23'd0, q8.pop_front()});
        end
        held8 = {cout, sum};
      end
    end
  end

  // Monitor for the WIDTH=4 instance
  always @(negedge clk) begin
    if (!rst_n) begin
      held4 = '0;
    end else begin
      if (busy4) chk("hold4", {27'd0, cout4, sum4}, {27'd0, held4});
      if (done4) begin
        dones4++;
        if (q4.size() == 0) begin
          chk("unexpected_done4", {31'd0, done4}, 32'd0);
        end else begin
          chk("result4", {27'd0, cout4, sum4}, {27'd0, q4.pop_front()});
        end
        held4 = {cout4, sum4};
      end
    end
  end

  task automatic issue8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                        input logic [8:0] exp, input bit push);
    a     = ia;
    b     = ib;
    cin   = ic;
    start = 1'b1;
    if (push) q8.push_back(exp);
    tick();
    start = 1'b0;
    chk("accept8", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done8();
    for (int i = 0; i < 40; i++) begin
      if (done) break;
      tick();
    end
    chk("done_seen8", {31'd0, done}, 32'd1);
    tick();
  endtask

  task automatic issue4(input logic [3:0] ia, input logic [3:0] ib, input logic ic);
    a4     = ia;
    b4     = ib;
    cin4   = ic;
    start4 = 1'b1;
    q4.push_back({1'b0, ia} + {1'b0, ib} + {4'd0, ic});
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done4) break;
      tick();
    end
    chk("done_seen4", {31'd0, done4}, 32'd1);
    tick();
  endtask

  initial begin
    int snap;
    int pos[$];
    logic [7:0] sa;
    logic [7:0] sb;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    cin    = 1'b0;
    start4 = 1'b0;
    a4     = '0;
    b4     = '0;
    cin4   = 1'b0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {23'd0, cout, sum}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 0 + 0: busy for exactly 8 cycles, then one done cycle
    issue8(8'h00, 8'h00, 1'b0, 9'h000, 1'b1);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("busy_window", {31'd0, busy}, 32'd1);
      chk("no_early_done", {31'd0, done}, 32'd0);
    end
    tick();
    chk("busy_end", {31'd0, busy}, 32'd0);
    chk("done_pulse", {31'd0, done}, 32'd1);
    tick();
    chk("done_one_cycle", {31'd0, done}, 32'd0);

    // Wrap into carry-out
    issue8(8'hFF, 8'h01, 1'b0, 9'h100, 1'b1);
    wait_done8();

    // Operand changes during the run must not matter
    issue8(8'hA5, 8'h5A, 1'b1, 9'h100, 1'b1);
    for (int i = 0; i < 7; i++) begin
      a   = 8'($urandom);
      b   = 8'($urandom);
      cin = 1'($urandom);
      tick();
    end
    wait_done8();

    // Re-pulsed start while busy is ignored
    issue8(8'h3C, 8'h0F, 1'b0, 9'h04B, 1'b1);
    snap = dones8;
    tick();
    tick();
    a     = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_repulse", {31'd0, busy}, 32'd1);
    wait_done8();
    for (int i = 0; i < 12; i++) tick();
    chk("single_done", 32'(dones8 - snap), 32'd1);

    // Reset in the middle of a run aborts it
    issue8(8'h12, 8'h34, 1'b0, 9'h000, 1'b0);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", {23'd0, cout, sum}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    snap  = dones8;
    for (int i = 0; i < 12; i++) tick();
    chk("no_done_after_abort", 32'(dones8 - snap), 32'd0);
    chk("result_after_abort", {23'd0, cout, sum}, 32'd0);
    issue8(8'h01, 8'h01, 1'b0, 9'h002, 1'b1);
    wait_done8();

    // start held high: one operation every 10 cycles
    a     = 8'h80;
    b     = 8'h80;
    cin   = 1'b0;
    q8.push_back(9'h100);
    q8.push_back(9'h100);
    q8.push_back(9'h100);
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 30) start = 1'b0;
      if (done) pos.push_back(c);
    end
    chk("held_done_count", 32'(pos.size()), 32'd3);
    if (pos.size() == 3) begin
      chk("held_first_done", 32'(pos[0]), 32'd9);
      chk("held_period_1", 32'(pos[1] - pos[0]), 32'd10);
      chk("held_period_2", 32'(pos[2] - pos[1]), 32'd10);
    end

    // WIDTH=8 operand sweep against the arithmetic model
    for (int i = 0; i < 256; i++) begin
      sa = 8'(i);
      sb = 8'(i * 37 + 11);
      issue8(sa, sb, sa[0], {1'b0, sa} + {1'b0, sb} + {8'd0, sa[0]}, 1'b1);
      wait_done8();
    end

    // Exhaustive check on the WIDTH=4 instance
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          issue4(4'(ia), 4'(ib), 1'(ic));
        end
      end
    end

    tick();
    tick();
    chk("queue8_drained", 32'(q8.size()), 32'd0);
    chk("queue4_drained", 32'(q4.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
